// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IF/LS memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

endpackage

// File: rtl/arb_owner_fifo.sv
// Owner FIFO: remembers which master issued each outstanding read so that
// in-order responses can be steered back to it.
module arb_owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  owner_e push_own,
  input  logic   pop,
  output owner_e head,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  owner_e           slots [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Slot contents are only meaningful while counted, so they carry no reset.
  always_ff @(posedge clk) begin
    if (push_ok) slots[wr_ptr] <= push_own;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IF and LS, with
// pipelined in-order reads. Optional counters under MEM_ARB_PERF_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUTST  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err_spurious
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_if_gnt,
  output logic [31:0]         perf_ls_gnt,
  output logic [31:0]         perf_conflict
`endif
);

  owner_e last_gnt;
  owner_e fifo_head;
  owner_e push_own;
  logic   fifo_full;
  logic   fifo_empty;
  logic   can_issue;
  logic   if_win;
  logic   ls_win;
  logic   push;
  logic   pop;

  // A full FIFO blocks every grant, writes included, even when a pop is
  // happening in the same cycle; rst gating keeps all grants low in reset.
  always_comb begin
    can_issue = rst & mem_ready & ~fifo_full;
    if_win    = can_issue & if_req & (~ls_req | (last_gnt == OWN_LS));
    ls_win    = can_issue & ls_req & (~if_req | (last_gnt == OWN_IF));
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (ls_win) begin
      mem_req   = 1'b1;
      mem_we    = ls_we;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      mem_wstrb = ls_wstrb;
    end else if (if_win) begin
      mem_req  = 1'b1;
      mem_addr = if_addr;
    end
  end

  assign if_gnt   = if_win;
  assign ls_gnt   = ls_win;
  assign push     = if_win | (ls_win & ~ls_we);
  assign push_own = ls_win ? OWN_LS : OWN_IF;
  assign pop      = mem_rvalid & ~fifo_empty;

  arb_owner_fifo #(
    .DEPTH(OUTST)
  ) u_owner_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_own(push_own),
    .pop     (pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    if_rvalid = pop & (fifo_head == OWN_IF);
    ls_rvalid = pop & (fifo_head == OWN_LS);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    ls_rdata  = ls_rvalid ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt     <= OWN_IF;
      err_spurious <= 1'b0;
    end else begin
      if (ls_win)      last_gnt <= OWN_LS;
      else if (if_win) last_gnt <= OWN_IF;
      if (mem_rvalid & fifo_empty) err_spurious <= 1'b1;
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_if_gnt   <= '0;
      perf_ls_gnt   <= '0;
      perf_conflict <= '0;
    end else begin
      if (if_win) perf_if_gnt <= perf_if_gnt + 32'd1;
      if (ls_win) perf_ls_gnt <= perf_ls_gnt + 32'd1;
      if (if_req & ls_req & can_issue) perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule
